// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand/result handshake bundle; master drives in_valid, A, B, Cin, Mode, out_ready; slave drives in_ready, out_valid, Y, Cout, Overflow, Zero
interface pipelined_alu_if #(
    parameter int WIDTH = 16,
    parameter int MODE_W = 4
);
    logic in_valid, in_ready, Cin, out_valid, out_ready, Cout, Overflow, Zero;
    logic [WIDTH-1:0] A, B, Y;
    logic [MODE_W-1:0] Mode;
    modport master(
        output in_valid, A, B, Cin, Mode, out_ready,
        input in_ready, out_valid, Y, Cout, Overflow, Zero
    );
    modport slave(
        input in_valid, A, B, Cin, Mode, out_ready,
        output in_ready, out_valid, Y, Cout, Overflow, Zero
    );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: one-op-in-flight registered ALU with flags and shift-add multiply; ports clk, rst (sync, active high), bus (slave side of pipelined_alu_if)
module pipelined_alu #(
    parameter int WIDTH = 16,
    parameter int MODE_W = 4,
    parameter int SHW = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst,
    pipelined_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam int NG = WIDTH / 4;
    state_t state, state_n;
    logic [WIDTH-1:0] a, b, bb, sum, res, ffo, a_cap, b_cap, y;
    logic [NG:0] gc;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [SHW-1:0] cnt;
    logic add, sub, is_mul, accept, last, cout, ovf, zero, res_ovf;
    assign a = bus.A;
    assign b = bus.B;
    assign add = bus.Mode == 4'd4;
    assign sub = bus.Mode == 4'd5;
    assign is_mul = bus.Mode == 4'd1;
    assign accept = bus.in_valid & bus.in_ready;
    assign last = cnt == SHW'(WIDTH - 1);
    assign bb = sub ? ~b : b;
    assign gc[0] = sub | (add & bus.Cin);
    for (genvar i = 0; i < NG; i++) begin : grp
        logic [3:0] p, g, c;
        assign p = a[4*i+:4] ^ bb[4*i+:4];
        assign g = a[4*i+:4] & bb[4*i+:4];
        assign c[0] = gc[i];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        assign gc[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
        assign sum[4*i+:4] = p ^ c;
    end
    // with bb already inverted for SUB, both overflow rules reduce to this one
    assign res_ovf = (add | sub) & (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    always_comb begin
        ffo = '0;
        for (int k = 0; k < WIDTH; k++)
            if (a[k]) ffo = WIDTH'(k + 1);
    end
    always_comb begin
        res = '0;
        case (bus.Mode)
            4'd0: res = a << 1;
            4'd2: res = a >> 1;
            4'd3: res = {a[WIDTH-1], a[WIDTH-1:1]};
            4'd4, 4'd5: res = sum;
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = ~a;
            4'd9: res = a ^ b;
            4'd10: res = ~(a ^ b);
            4'd11: res = ~(a | b);
            4'd12: res = {{(WIDTH-1){1'b0}}, 1'b1} << a[SHW-1:0];
            4'd13: res = {{(WIDTH-1){1'b0}}, a < b};
            4'd14: res = b;
            4'd15: res = ffo;
            default: res = '0;
        endcase
    end
    assign acc_n = acc + (b_cap[cnt] ? {{WIDTH{1'b0}}, a_cap} << cnt : '0);
    always_comb begin
        state_n = state == IDLE ? (accept ? (is_mul ? MUL : DONE) : IDLE)
                : state == MUL  ? (last ? DONE : MUL)
                :                 (bus.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            y <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_cap <= a;
                b_cap <= b;
                cnt <= '0;
                acc <= '0;
            end
            if (accept & ~is_mul) begin
                y <= res;
                cout <= (add | sub) & gc[NG];
                ovf <= res_ovf;
                zero <= res == '0;
            end
            if (state == MUL) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
            end
            if (state == MUL && last) begin
                y <= acc_n[WIDTH-1:0];
                cout <= 1'b0;
                ovf <= |acc_n[2*WIDTH-1:WIDTH];
                zero <= acc_n[WIDTH-1:0] == '0;
            end
        end
    end
    assign bus.in_ready = (state == IDLE) & ~rst;
    assign bus.out_valid = state == DONE;
    assign bus.Y = y;
    assign bus.Cout = cout;
    assign bus.Overflow = ovf;
    assign bus.Zero = zero;
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: scoreboard bench for 16- and 8-bit pipelined_alu instances
module tb_pipelined_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pipelined_alu_if #(.WIDTH(16)) b16();
    pipelined_alu_if #(.WIDTH(8)) b8();
    pipelined_alu #(.WIDTH(16)) dut16(.clk(clk), .rst(rst), .bus(b16.slave));
    pipelined_alu #(.WIDTH(8)) dut8(.clk(clk), .rst(rst), .bus(b8.slave));
    typedef struct packed {
        logic [15:0] y;
        logic c;
        logic o;
        logic z;
    } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t mk(input logic [15:0] y, input logic c, input logic o);
        exp_t e;
        e.y = y;
        e.c = c;
        e.o = o;
        e.z = y == 16'd0;
        return e;
    endfunction
    function automatic exp_t model(input int w, input logic [3:0] m, input logic [15:0] ai, input logic [15:0] bi, input logic c);
        logic [32:0] msk, a, b, y, s;
        logic co, ov;
        msk = (33'd1 << w) - 33'd1;
        a = {17'd0, ai} & msk;
        b = {17'd0, bi} & msk;
        y = '0;
        co = 1'b0;
        ov = 1'b0;
        case (m)
            4'd0: y = a << 1;
            4'd1: begin
                s = a * b;
                y = s;
                ov = (s >> w) != 33'd0;
            end
            4'd2: y = a >> 1;
            4'd3: y = (a >> 1) | (a & (33'd1 << (w - 1)));
            4'd4: begin
                s = a + b + {32'd0, c};
                y = s;
                co = s[w];
                ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
            end
            4'd5: begin
                s = a + (~b & msk) + 33'd1;
                y = s;
                co = s[w];
                ov = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
            end
            4'd6: y = a & b;
            4'd7: y = a | b;
            4'd8: y = ~a;
            4'd9: y = a ^ b;
            4'd10: y = ~(a ^ b);
            4'd11: y = ~(a | b);
            4'd12: y = 33'd1 << (a & 33'(w - 1));
            4'd13: y = {32'd0, a < b};
            4'd14: y = b;
            default: for (int i = 0; i < w; i++) if (a[i]) y = 33'(i + 1);
        endcase
        y = y & msk;
        return mk(y[15:0], co, ov);
    endfunction
    task automatic drive(input bit w8, input logic v, input logic [3:0] m, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (w8) begin
            b8.in_valid = v; b8.Mode = m; b8.A = a[7:0]; b8.B = b[7:0]; b8.Cin = c;
        end else begin
            b16.in_valid = v; b16.Mode = m; b16.A = a; b16.B = b; b16.Cin = c;
        end
    endtask
    task automatic scramble(input bit w8, input logic v);
        drive(w8, v, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    endtask
    task automatic peek(input bit w8, output logic ov, output logic ir, output logic [15:0] y, output logic c, output logic o, output logic z);
        ov = w8 ? b8.out_valid : b16.out_valid;
        ir = w8 ? b8.in_ready : b16.in_ready;
        y = w8 ? {8'd0, b8.Y} : b16.Y;
        c = w8 ? b8.Cout : b16.Cout;
        o = w8 ? b8.Overflow : b16.Overflow;
        z = w8 ? b8.Zero : b16.Zero;
    endtask
    task automatic run(input bit w8, input logic [3:0] m, input logic [15:0] a, input logic [15:0] b, input logic c, input exp_t e, input int hold);
        logic ov, ir, cc, oo, zz, c0, o0, z0;
        logic [15:0] y, y0;
        int lat, bad, elat;
        exp_t x;
        elat = m == 4'd1 ? (w8 ? 9 : 17) : 1;
        lat = 0;
        peek(w8, ov, ir, y, cc, oo, zz);
        while (!ir && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            peek(w8, ov, ir, y, cc, oo, zz);
        end
        check("in_ready_idle", ir, 1);
        drive(w8, 1'b1, m, a, b, c);
        @(posedge clk); #1;
        sb.push_back(e);
        scramble(w8, 1'b0);
        lat = 1;
        bad = 0;
        peek(w8, ov, ir, y, cc, oo, zz);
        while (!ov && lat < 40) begin
            if (ir) bad++;
            @(posedge clk); #1;
            lat++;
            peek(w8, ov, ir, y, cc, oo, zz);
        end
        check($sformatf("latency_m%0d", m), lat, elat);
        check("in_ready_busy", bad, 0);
        check("in_ready_done", ir, 0);
        x = sb.pop_front();
        check($sformatf("y_m%0d", m), y, x.y);
        check($sformatf("cout_m%0d", m), cc, x.c);
        check($sformatf("ovf_m%0d", m), oo, x.o);
        check($sformatf("zero_m%0d", m), zz, x.z);
        {y0, c0, o0, z0} = {y, cc, oo, zz};
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            scramble(w8, 1'($urandom));
            @(posedge clk); #1;
            peek(w8, ov, ir, y, cc, oo, zz);
            if (!ov || ir || {y, cc, oo, zz} !== {y0, c0, o0, z0}) bad++;
        end
        scramble(w8, 1'b0);
        if (hold > 0) check("hold_stable", bad, 0);
        if (w8) b8.out_ready = 1'b1; else b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        b16.out_ready = 1'b0;
        peek(w8, ov, ir, y, cc, oo, zz);
        check("out_valid_clr", ov, 0);
        check("in_ready_back", ir, 1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        logic ov, ir, cc, oo, zz;
        logic [15:0] y;
        logic [3:0] m;
        logic [15:0] a, b;
        logic c;
        bit w8;
        drive(0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        b16.out_ready = 1'b0;
        b8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        peek(0, ov, ir, y, cc, oo, zz);
        check("rst_out_valid", ov, 0);
        check("rst_in_ready", ir, 0);
        check("rst_y", y, 0);
        check("rst_flags", {cc, oo, zz}, 0);
        rst = 1'b0;
        #1;
        peek(0, ov, ir, y, cc, oo, zz);
        check("rel_in_ready", ir, 1);
        run(0, 4'd4, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), 0);
        run(0, 4'd4, 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1'b1, 1'b0), 0);
        run(0, 4'd5, 16'h0003, 16'h0005, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 0);
        run(0, 4'd5, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b1, 1'b1), 0);
        run(0, 4'd1, 16'h0100, 16'h0100, 1'b0, mk(16'h0000, 1'b0, 1'b1), 0);
        run(0, 4'd1, 16'h00FF, 16'h0003, 1'b0, mk(16'h02FD, 1'b0, 1'b0), 0);
        run(0, 4'd4, 16'h1234, 16'h1111, 1'b0, mk(16'h2345, 1'b0, 1'b0), 5);
        drive(0, 1'b1, 4'd1, 16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        scramble(0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        peek(0, ov, ir, y, cc, oo, zz);
        check("midmul_out_valid", ov, 0);
        check("midmul_y", y, 0);
        check("midmul_flags", {cc, oo, zz}, 0);
        check("midmul_in_ready_rst", ir, 0);
        rst = 1'b0;
        #1;
        peek(0, ov, ir, y, cc, oo, zz);
        check("midmul_in_ready", ir, 1);
        run(0, 4'd4, 16'd2, 16'd3, 1'b0, mk(16'd5, 1'b0, 1'b0), 0);
        run(1, 4'd15, 16'h00, 16'h00, 1'b0, mk(16'h00, 1'b0, 1'b0), 0);
        run(1, 4'd15, 16'h01, 16'h00, 1'b0, mk(16'h01, 1'b0, 1'b0), 0);
        run(1, 4'd15, 16'h80, 16'h00, 1'b0, mk(16'h08, 1'b0, 1'b0), 0);
        run(1, 4'd12, 16'h07, 16'h00, 1'b0, mk(16'h80, 1'b0, 1'b0), 0);
        run(1, 4'd13, 16'h05, 16'h80, 1'b0, mk(16'h01, 1'b0, 1'b0), 0);
        for (int i = 0; i < 80; i++) begin
            w8 = 1'($urandom);
            m = i < 32 ? 4'(i) : 4'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            run(w8, m, a, b, c, model(w8 ? 8 : 16, m, a, b, c), $urandom_range(0, 2));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
